// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with mid-bit sampling FSM and show-ahead receive FIFO.
//
// Optional feature: define UART_RX_PARITY_EN to receive one parity bit between the data
// and stop bits (even parity, or odd when PARITY_ODD = 1). Without it there is no parity
// bit in the frame and parity_err is tied to 0.
//
// Ports:
//   clk        - single clock
//   rst        - asynchronous active-high reset
//   rx         - asynchronous serial input, idles high
//   rd_en      - pop the head entry (ignored while empty)
//   clr_ovr    - clear the sticky overrun flag
//   rd_valid   - FIFO non-empty
//   rd_data    - head entry data
//   frame_err  - head entry stop-bit error
//   parity_err - head entry parity error
//   overrun    - sticky: a frame was dropped because the FIFO was full
//   busy       - receiver FSM not idle
//   level      - number of FIFO entries (0..FIFO_DEPTH)
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_ovr,
  output logic                          rd_valid,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned H     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
  localparam int unsigned EntryW = DATA_BITS + 2;
  localparam logic        ParityOdd = 1'(PARITY_ODD);
`else
  localparam int unsigned EntryW = DATA_BITS + 1;
`endif

  typedef logic [CntW-1:0]  cnt_t;
  typedef logic [BitW-1:0]  bit_t;
  typedef logic [AddrW:0]   level_t;

  localparam cnt_t   HalfReload = cnt_t'(H - 1);
  localparam cnt_t   BitReload  = cnt_t'(CLKS_PER_BIT - 1);
  localparam bit_t   LastBit    = bit_t'(DATA_BITS - 1);
  localparam level_t FullLevel  = level_t'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  // Input synchroniser; resets to the idle (high) line level so reset never looks like a start.
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver FSM
  state_e               state_q;
  cnt_t                 cnt_q;
  bit_t                 bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 sample;
  logic                 push;
  logic [EntryW-1:0]    push_entry;

  assign sample = (cnt_q == '0);
  assign push   = (state_q == StStop) && sample;

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  assign push_entry = {perr_q, ~rx_sync_q, shift_q};
`else
  logic unused_parity_odd;
  assign unused_parity_odd = ^PARITY_ODD;
  assign push_entry = {~rx_sync_q, shift_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_q - 1'b1;
      case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            state_q <= StStart;
            cnt_q   <= HalfReload;
          end
        end
        StStart: begin
          if (sample) begin
            if (!rx_sync_q) begin
              state_q <= StData;
              cnt_q   <= BitReload;
              bit_q   <= '0;
            end else begin
              // Glitch shorter than half a bit: not a real start bit.
              state_q <= StIdle;
            end
          end
        end
        StData: begin
          if (sample) begin
            shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
            cnt_q   <= BitReload;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (sample) begin
            perr_q  <= (^shift_q) ^ rx_sync_q ^ ParityOdd;
            cnt_q   <= BitReload;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (sample) begin
            // Return straight to idle on a good stop bit so back-to-back frames are caught.
            state_q <= rx_sync_q ? StIdle : StWaitHigh;
          end
        end
        StWaitHigh: begin
          // Break condition: wait for the line to return high before hunting for a start.
          if (rx_sync_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  // Receive FIFO
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  level_t            count_q;
  logic              overrun_q;
  logic              full, pop, wr_en;
  logic [EntryW-1:0] head;

  assign full  = (count_q == FullLevel);
  assign pop   = rd_en && (count_q != '0);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      // Pointers wrap naturally since the depth is a power of two.
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Set wins over a simultaneous clear.
      if (push && full && !pop) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Head is masked while empty so all outputs read 0 out of reset.
  assign head      = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rd_valid  = (count_q != '0);
  assign level     = count_q;
  assign overrun   = overrun_q;
  assign rd_data   = head[DATA_BITS-1:0];
  assign frame_err = head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
  assign parity_err = head[DATA_BITS+1];
`else
  assign parity_err = 1'b0;
`endif

endmodule
